// File: rtl/imm_ext_pipe.sv
// ----------------------------------------------------------------------------
// imm_ext_pipe
//   Pipelined immediate-extension unit for the decode->execute path.
//   An IN_W-bit immediate is extended to OUT_W bits on entry according to a
//   2-bit mode. It is stored already extended in a 2-entry skid buffer, and a
//   sideband tag travels with it unchanged. Every output is a register.
//
//   Optional feature macro: IMMEXT_SHL2_EN
//     defined   : mode 11 = SIGN result shifted left by 2 (top 2 bits wrap off)
//     undefined : mode 11 decodes as SIGN; the shifter is not built
//
// Parameters
//   IN_W   immediate input width (legal when IN_W+2 <= OUT_W)
//   OUT_W  extended output width
//   TAG_W  sideband tag width
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-low
//   flush      in   1      synchronous drop of all buffered entries
//   in_valid   in   1      input immediate valid
//   in_ready   out  1      input can be accepted this cycle (registered)
//   in_imm     in   IN_W   raw immediate
//   in_mode    in   2      00 SIGN, 01 ZERO, 10 UPPER, 11 SHL2
//   in_tag     in   TAG_W  sideband tag
//   out_valid  out  1      head entry valid
//   out_ready  in   1      consumer accepts the head entry this cycle
//   out_data   out  OUT_W  extended immediate of the head entry
//   out_tag    out  TAG_W  tag of the head entry
// ----------------------------------------------------------------------------
module imm_ext_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_SHL2  = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] data;
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   in_ready_q;
    logic   out_valid_q;

    logic   in_fire;
    logic   out_fire;
    entry_t new_entry;

    // Extension candidates, all computed from the raw immediate
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] ext_data;

    assign sign_ext  = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign zero_ext  = {{EXT_W{1'b0}}, in_imm};
    assign upper_ext = {in_imm, {EXT_W{1'b0}}};

`ifdef IMMEXT_SHL2_EN
    logic [OUT_W-1:0] shl2_ext;
    // Branch offset: sign-extend then x4, top two bits wrap away
    assign shl2_ext = {sign_ext[OUT_W-3:0], 2'b00};
`endif

    // Mode decode
    always_comb begin
        ext_data = sign_ext;
        case (in_mode)
            MODE_SIGN:  ext_data = sign_ext;
            MODE_ZERO:  ext_data = zero_ext;
            MODE_UPPER: ext_data = upper_ext;
`ifdef IMMEXT_SHL2_EN
            MODE_SHL2:  ext_data = shl2_ext;
`else
            MODE_SHL2:  ext_data = sign_ext;
`endif
            default:    ext_data = sign_ext;
        endcase
    end

    assign new_entry = '{tag: in_tag, data: ext_data};
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;

    // Occupancy FSM and entry movement; head is always the entry on the output
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        tail_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (!in_fire && out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        // Head leaves, new entry replaces it directly
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and output registers; handshake flags are precomputed from state_d
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q.data;
    assign out_tag   = head_q.tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_ext_pipe
//   Self-checking bench for imm_ext_pipe (default parameters 16/32/5).
//   Directed scenarios use hand-derived constants; the random scenario is
//   compared against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_imm_ext_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    imm_ext_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } ment_t;

    ment_t mq[$];
    bit    m_rdy = 1'b1;

    // Extension by arithmetic on the immediate's numeric value
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint s;
        longint u;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            2'd0: return 32'(s);
            2'd1: return 32'(u);
            2'd2: return 32'(u * 65536);
`ifdef IMMEXT_SHL2_EN
            default: return 32'(s * 4);
`else
            default: return 32'(s);
`endif
        endcase
    endfunction

    always @(posedge clk) begin
        bit in_f;
        bit out_f;
        if (!rst) begin
            mq.delete();
            m_rdy = 1'b1;
        end else begin
            in_f  = in_valid && m_rdy;
            out_f = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (out_f) void'(mq.pop_front());
                if (in_f)  mq.push_back('{tag: in_tag, data: ref_ext(in_imm, in_mode)});
            end
            m_rdy = (mq.size() < 2);
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_mode = '0; in_tag = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h exp 0", out_tag); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_extension();
        logic [15:0] imms [4];
        logic [1:0]  modes[4];
        logic [31:0] exps [4];
        imms[0] = 16'h8000; modes[0] = 2'b00; exps[0] = 32'hFFFF_8000;
        imms[1] = 16'h8000; modes[1] = 2'b01; exps[1] = 32'h0000_8000;
        imms[2] = 16'h1234; modes[2] = 2'b10; exps[2] = 32'h1234_0000;
`ifdef IMMEXT_SHL2_EN
        imms[3] = 16'hFFFF; modes[3] = 2'b11; exps[3] = 32'hFFFF_FFFC;
`else
        imms[3] = 16'hFFFF; modes[3] = 2'b11; exps[3] = 32'hFFFF_FFFF;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_imm = imms[i]; in_mode = modes[i]; in_tag = 5'(i + 4);
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ext_valid[%0d]: got %b exp 1", i, out_valid); end
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL ext_data[%0d]: got %h exp %h", i, out_data, exps[i]); end
            checks++; if (out_tag !== 5'(i + 4)) begin errors++; $display("FAIL ext_tag[%0d]: got %0d exp %0d", i, out_tag, i + 4); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ext_drained[%0d]: got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got[$];
        bit         in_f;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'($urandom); in_tag = 5'd1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one: got %b exp 1", in_ready); end
        in_imm = 16'($urandom); in_tag = 5'd2;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b exp 0", in_ready); end
        in_imm = 16'($urandom); in_tag = 5'd3;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b exp 0", in_ready); end
        checks++; if (out_tag !== 5'd1) begin errors++; $display("FAIL b2b_head_held: got %0d exp 1", out_tag); end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid && out_ready) got.push_back(out_tag);
            in_f = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (in_f) in_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++; $display("FAIL b2b_order[%0d]: got none exp %0d", i, i + 1);
            end else if (got[i] !== 5'(i + 1)) begin
                errors++; $display("FAIL b2b_order[%0d]: got %0d exp %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_simul_fire();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0005; in_mode = 2'b01; in_tag = 5'd10;
        @(negedge clk);
        checks++; if (out_tag !== 5'd10) begin errors++; $display("FAIL simul_first: got %0d exp 10", out_tag); end
        in_imm = 16'hABCD; in_mode = 2'b00; in_tag = 5'd11; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b exp 1", out_valid); end
        checks++; if (out_tag !== 5'd11) begin errors++; $display("FAIL simul_tag: got %0d exp 11", out_tag); end
        checks++; if (out_data !== 32'hFFFF_ABCD) begin errors++; $display("FAIL simul_data: got %h exp ffffabcd", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b exp 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_one_entry: got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0020; in_tag = 5'd20;
        @(negedge clk);
        in_imm = 16'h0021; in_tag = 5'd21;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got %b exp 0", in_ready); end
        flush = 1'b1; in_imm = 16'h0022; in_tag = 5'd22;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", in_ready); end
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_emitted: got %0d exp 0", seen); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b10; in_imm = 16'h00F0; in_tag = 5'd30;
        @(negedge clk);
        in_tag = 5'd31;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h exp 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b exp 1", in_ready); end
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0001; in_tag = 5'd7;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_push_valid: got %b exp 1", out_valid); end
        checks++; if (out_tag !== 5'd7) begin errors++; $display("FAIL rmid_push_tag: got %0d exp 7", out_tag); end
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL rmid_push_data: got %h exp 1", out_data); end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit exp_v;
        for (int c = 0; c < 400; c++) begin
            exp_v = (mq.size() != 0);
            checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b exp %b", c, in_ready, m_rdy); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_valid@%0d: got %b exp %b", c, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_data !== mq[0].data) begin errors++; $display("FAIL rnd_data@%0d: got %h exp %h", c, out_data, mq[0].data); end
                checks++; if (out_tag !== mq[0].tag) begin errors++; $display("FAIL rnd_tag@%0d: got %0d exp %0d", c, out_tag, mq[0].tag); end
            end
            in_valid  = 1'($urandom_range(0, 1));
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_extension();
        test_back_to_back();
        test_simul_fire();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
